mem_responder: RTL

- Memory-side responder for the CPU's shared 6-bit address bus and bidirectional 8-bit data bus.
- Holds a 64x8 word store and serves reads and writes issued by the controller/datapath pair.
- Uses a four-phase request/ready handshake with a programmable number of wait states.
- Includes a preload port so benches and boot logic can load a program while the block is idle.

---
 rtl/mem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder for a shared address bus and bidirectional
//            data bus. Holds a 2**ADR_W x DATA_W word store and serves read
//            and write requests with a four-phase request/ready handshake and
//            a programmable number of wait states. A preload port lets boot
//            logic fill the store while the block is idle.
// Ports    : clk        - rising-edge clock
//            reset      - synchronous, active-high reset
//            adr_bus    - access address, sampled when a request is captured
//            data_bus   - write data in; read data out (driven in RD_DONE only)
//            read_mem   - read request level
//            write_mem  - write request level
//            mem_ready  - registered access-complete flag
//            proto_err  - one-cycle pulse when read and write are both high
//            ld_en      - preload strobe (honoured only in IDLE, no request)
//            ld_adr     - preload address
//            ld_data    - preload data
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADR_W       = 6,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADR_W-1:0]  adr_bus,
    inout  wire  [DATA_W-1:0] data_bus,
    input  logic              read_mem,
    input  logic              write_mem,
    output logic              mem_ready,
    output logic              proto_err,
    input  logic              ld_en,
    input  logic [ADR_W-1:0]  ld_adr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int         c_DEPTH    = 1 << ADR_W;
    localparam bit         c_NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0] c_CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_BUSY    = 3'd1;
    localparam logic [2:0] c_RD_DONE = 3'd2;
    localparam logic [2:0] c_WR_DONE = 3'd3;
    localparam logic [2:0] c_RELEASE = 3'd4;

    logic [2:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADR_W-1:0]  r_adr_q;
    logic [DATA_W-1:0] r_wdata_q;
    logic [DATA_W-1:0] r_rdata_q;
    logic              r_is_rd;
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              w_idle;
    logic              w_cap_rd;
    logic              w_cap_wr;
    logic              w_cap;
    logic              w_done;
    logic              w_acc_rd;
    logic [ADR_W-1:0]  w_acc_adr;
    logic [DATA_W-1:0] w_acc_wdata;
    logic              w_preload;
    logic              w_mem_we;
    logic [ADR_W-1:0]  w_mem_wadr;
    logic [DATA_W-1:0] w_mem_wdata;

    // With zero wait states the DONE step happens on the capture edge itself,
    // so the access fields come straight from the bus instead of the latches.
    always_comb begin
        w_idle      = (r_state == c_IDLE);
        w_cap_rd    = w_idle && read_mem && !write_mem;
        w_cap_wr    = w_idle && write_mem && !read_mem;
        w_cap       = w_cap_rd || w_cap_wr;
        w_done      = (w_cap && c_NO_WAIT) || ((r_state == c_BUSY) && (r_cnt == 4'd0));
        w_acc_rd    = w_idle ? w_cap_rd : r_is_rd;
        w_acc_adr   = w_idle ? adr_bus  : r_adr_q;
        w_acc_wdata = w_idle ? data_bus : r_wdata_q;
        w_preload   = w_idle && ld_en && !read_mem && !write_mem;
        // Reset wins over a commit landing on the same edge.
        w_mem_we    = !reset && ((w_done && !w_acc_rd) || w_preload);
        w_mem_wadr  = w_preload ? ld_adr  : w_acc_adr;
        w_mem_wdata = w_preload ? ld_data : w_acc_wdata;
    end

    // Only the read-data register drives the bus, and only in RD_DONE.
    assign data_bus = (r_state == c_RD_DONE) ? r_rdata_q : {DATA_W{1'bz}};

    // Word store: contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_wadr] <= w_mem_wdata;
        end
        if (w_done && w_acc_rd) begin
            r_rdata_q <= r_mem[w_acc_adr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= 4'd0;
            r_adr_q   <= '0;
            r_wdata_q <= '0;
            r_is_rd   <= 1'b0;
            mem_ready <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (read_mem && write_mem) begin
                        proto_err <= 1'b1;
                    end else if (w_cap) begin
                        r_adr_q <= adr_bus;
                        r_is_rd <= w_cap_rd;
                        if (w_cap_wr) begin
                            r_wdata_q <= data_bus;
                        end
                        if (!c_NO_WAIT) begin
                            r_state <= c_BUSY;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end
                end
                c_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RD_DONE: begin
                    if (!read_mem) begin
                        mem_ready <= 1'b0;
                        r_state   <= c_RELEASE;
                    end
                end
                c_WR_DONE: begin
                    if (!write_mem) begin
                        mem_ready <= 1'b0;
                        r_state   <= c_RELEASE;
                    end
                end
                c_RELEASE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            // DONE step, from IDLE (no wait states) or from BUSY.
            if (w_done) begin
                r_state   <= w_acc_rd ? c_RD_DONE : c_WR_DONE;
                mem_ready <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
